// File: rtl/tm1638_responder.sv
// tm1638_responder
// Responder-side model of a TM1638 LED&KEY board. Oversamples the
// controller's serial pins on the system clock, decodes data, address and
// display-control commands into a 16-byte display register file, and
// shifts key-scan bytes back toward the controller on read commands.
//
// Ports:
//   clock, reset     system clock, asynchronous active-high reset
//   sio_clk/sio_stb  serial clock and active-low strobe from the controller
//   sio_data         controller data (sampled on sio_clk rising edges)
//   sio_data_en      controller drive enable, used only to flag contention
//   dio_out/_en      responder data toward the controller and its enable
//   keys             key states, 1 = pressed
//   seg              seg[8*i +: 8] = display register 2*i
//   led              led[i] = bit 0 of display register 2*i+1
//   display_on       display-control bit 3
//   brightness       display-control bits [2:0]
//   protocol_error   one-cycle pulse per cycle with a detected violation
module tm1638_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sio_clk,
  input  logic        sio_stb,
  input  logic        sio_data,
  input  logic        sio_data_en,
  output logic        dio_out,
  output logic        dio_out_en,
  input  logic [7:0]  keys,
  output logic [63:0] seg,
  output logic [7:0]  led,
  output logic        display_on,
  output logic [2:0]  brightness,
  output logic        protocol_error
);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, IGNORE} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, stb_sync, dat_sync;
  logic                   clk_hist, stb_hist;
  logic                   clk_s, stb_s, dat_s;
  logic                   clk_rise, clk_fall, stb_rise;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic [3:0]  ptr;
  logic        mode_fixed, mode_read;
  logic        ctrl_on;
  logic [2:0]  ctrl_bri;
  logic [7:0]  key_snap;
  logic [5:0]  rd_idx, rd_next;
  logic        rise_seen;
  logic        byte_done, err_next;
  logic [7:0]  regs [16];

  // Key-scan bit for serial position idx: byte j = {3'b0, k[j+4], 3'b0, k[j]}.
  // Positions 32 and beyond read as 0.
  function automatic logic key_bit(input logic [7:0] k, input logic [5:0] idx);
    logic r;
    r = 1'b0;
    if (!idx[5]) begin
      if (idx[2:0] == 3'd0) r = k[{1'b0, idx[4:3]}];
      else if (idx[2:0] == 3'd4) r = k[{1'b1, idx[4:3]}];
    end
    return r;
  endfunction

  // Synchronizers plus one history flop; strobe and clock idle high so
  // they reset high to avoid a spurious edge after reset release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      stb_sync <= '1;
      dat_sync <= '0;
      clk_hist <= 1'b1;
      stb_hist <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], sio_clk};
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], sio_stb};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], sio_data};
      clk_hist <= clk_s;
      stb_hist <= stb_s;
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign stb_s = stb_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Clock edges count only while the strobe is low.
  assign clk_rise = ~stb_s &  clk_s & ~clk_hist;
  assign clk_fall = ~stb_s & ~clk_s &  clk_hist;
  assign stb_rise =  stb_s & ~stb_hist;

  assign shift_next = {dat_s, shift[7:1]};
  assign byte_done  = clk_rise && (bit_cnt == 3'd7) && (state == CMD || state == WRITE);
  assign rd_next    = rd_idx[5] ? rd_idx : rd_idx + 6'd1;

  // All violations in one cycle merge into a single pulse.
  assign err_next = (state == CMD   && byte_done && shift_next[7:6] == 2'b00) ||
                    (state == WRITE && byte_done && mode_read) ||
                    (stb_rise && bit_cnt != 3'd0) ||
                    (sio_data_en && dio_out_en);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= 3'd0;
      shift          <= 8'd0;
      ptr            <= 4'd0;
      mode_fixed     <= 1'b0;
      mode_read      <= 1'b0;
      ctrl_on        <= 1'b0;
      ctrl_bri       <= 3'd0;
      key_snap       <= 8'd0;
      rd_idx         <= 6'd0;
      rise_seen      <= 1'b0;
      dio_out        <= 1'b0;
      dio_out_en     <= 1'b0;
      protocol_error <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else begin
      protocol_error <= err_next;
      if (stb_rise) begin
        // End of strobe; a partial byte in the shifter is simply dropped.
        state      <= IDLE;
        bit_cnt    <= 3'd0;
        dio_out    <= 1'b0;
        dio_out_en <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!stb_s) begin
              state   <= CMD;
              bit_cnt <= 3'd0;
            end
          end
          CMD: begin
            if (clk_rise) begin
              shift   <= shift_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                case (shift_next[7:6])
                  2'b01: begin
                    mode_fixed <= shift_next[2];
                    mode_read  <= shift_next[1];
                    if (shift_next[1]) begin
                      state      <= READ;
                      key_snap   <= keys;
                      rd_idx     <= 6'd0;
                      rise_seen  <= 1'b0;
                      dio_out    <= keys[0];
                      dio_out_en <= 1'b1;
                    end else begin
                      state <= IGNORE;
                    end
                  end
                  2'b10: begin
                    ctrl_on  <= shift_next[3];
                    ctrl_bri <= shift_next[2:0];
                    state    <= IGNORE;
                  end
                  2'b11: begin
                    ptr   <= shift_next[3:0];
                    state <= WRITE;
                  end
                  default: state <= IGNORE;
                endcase
              end
            end
          end
          WRITE: begin
            if (clk_rise) begin
              shift   <= shift_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && !mode_read) begin
                regs[ptr] <= shift_next;
                if (!mode_fixed) ptr <= ptr + 4'd1;
              end
            end
          end
          READ: begin
            // Advance only on a falling edge that follows a sampled rising
            // edge, so the idle-high clock's first fall keeps bit 0 up.
            if (clk_rise) begin
              rise_seen <= 1'b1;
            end else if (clk_fall && rise_seen) begin
              rise_seen <= 1'b0;
              rd_idx    <= rd_next;
              dio_out   <= key_bit(key_snap, rd_next);
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Registered output view of the register file and display control.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg        <= 64'd0;
      led        <= 8'd0;
      display_on <= 1'b0;
      brightness <= 3'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        seg[8*i +: 8] <= regs[2*i];
        led[i]        <= regs[2*i+1][0];
      end
      display_on <= ctrl_on;
      brightness <= ctrl_bri;
    end
  end

endmodule
